// File: rtl/calc_pkg.sv
// Shared types, instruction field layout and the fixed program ROM for the calculator.
package calc_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned INSTR_W   = 22;
  localparam int unsigned IM_ADDR_W = 4;
  localparam int unsigned TM_ADDR_W = 4;

  localparam int unsigned OP_LSB   = 18;
  localparam int unsigned A_LSB    = 10;
  localparam int unsigned B_LSB    = 2;
  localparam int unsigned MASK_LSB = 0;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpMul  = 4'h3,
    OpAnd  = 4'h4,
    OpOr   = 4'h5,
    OpXor  = 4'h6,
    OpCat  = 4'h7,
    OpHalt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StWrite   = 3'd4,
    StHalt    = 3'd5
  } state_e;

  localparam logic [INSTR_W-1:0] HALT_WORD = {4'hF, 18'd0};

  localparam logic [INSTR_W-1:0] ROM_CONTENTS [16] = '{
    {4'h7, 8'hBA, 8'h12, 2'b11},
    {4'h7, 8'h1D, 8'h1D, 2'b11},
    {4'h1, 8'h10, 8'h0D, 2'b11},
    {4'h1, 8'h8E, 8'h8D, 2'b11},
    HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD,
    HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD,
    HALT_WORD, HALT_WORD, HALT_WORD, HALT_WORD
  };

  // Only opcodes 1..7 produce a result worth storing; 0 and 8..E behave as NOP.
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h7);
  endfunction

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
    logic [15:0] r;
    r = '0;
    case (op)
      4'h1:    r = {7'd0, ({1'b0, a} + {1'b0, b})};
      4'h2:    r = {8'd0, a} - {8'd0, b};
      4'h3:    r = {8'd0, a} * {8'd0, b};
      4'h4:    r = {8'd0, a & b};
      4'h5:    r = {8'd0, a | b};
      4'h6:    r = {8'd0, a ^ b};
      4'h7:    r = {a, b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_trans_mem.sv
// 16x8 transaction memory: synchronous write port A, registered read port B, cleared on reset.
module calc_trans_mem #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wen_a_i,
  input  logic [AddrW-1:0] addr_a_i,
  input  logic [DataW-1:0] din_a_i,
  input  logic             ren_b_i,
  input  logic [AddrW-1:0] addr_b_i,
  output logic [DataW-1:0] dout_b_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] dout_q;

  // Read samples the pre-write contents, so a same-address collision returns old data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else begin
      if (wen_a_i) mem_q[addr_a_i] <= din_a_i;
      if (ren_b_i) dout_q <= mem_q[addr_b_i];
    end
  end

  assign dout_b_o = dout_q;

endmodule

// File: rtl/top.sv
// Programmable calculator: controller FSM runs the fixed ROM program through the ALU and
// stores result bytes into two transaction memories.
module top
  import calc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  Trans_Mem1_ADDRB,
  input  logic        Trans_Mem1_RENB,
  input  logic [3:0]  Trans_Mem2_ADDRB,
  input  logic        Trans_Mem2_RENB,
  output logic [7:0]  Trans_Mem1_DOUTB,
  output logic [7:0]  Trans_Mem2_DOUTB,
  output logic [2:0]  controller_state,
  output logic [21:0] current_instruction,
  output logic        IN_MEM_CNT_EN,
  output logic        TM_MEM1_CNT_EN,
  output logic        TM_MEM2_CNT_EN
);

  state_e                 state_q, state_d;
  logic [IM_ADDR_W-1:0]   pc_q;
  logic [TM_ADDR_W-1:0]   wp1_q, wp2_q;
  logic [INSTR_W-1:0]     rom_q, instr_q;
  logic [15:0]            result_q;

  logic [3:0]        op;
  logic [DATA_W-1:0] opa, opb;
  logic [1:0]        mask;
  logic              in_en, tm1_en, tm2_en;

  assign op   = instr_q[OP_LSB +: 4];
  assign opa  = instr_q[A_LSB +: DATA_W];
  assign opb  = instr_q[B_LSB +: DATA_W];
  assign mask = instr_q[MASK_LSB +: 2];

  always_comb begin
    state_d = state_q;
    in_en   = 1'b0;
    tm1_en  = 1'b0;
    tm2_en  = 1'b0;
    case (state_q)
      StIdle:    state_d = StFetch;
      StFetch:   state_d = StDecode;
      StDecode:  state_d = StExecute;
      StExecute: state_d = (op == OpHalt) ? StHalt : StWrite;
      StWrite: begin
        in_en   = 1'b1;
        tm1_en  = op_writes(op) && mask[0];
        tm2_en  = op_writes(op) && mask[1];
        // The last ROM slot never wraps back to 0.
        state_d = (pc_q == '1) ? StHalt : StFetch;
      end
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      wp1_q    <= '0;
      wp2_q    <= '0;
      rom_q    <= '0;
      instr_q  <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch)   rom_q    <= ROM_CONTENTS[pc_q];
      if (state_q == StDecode)  instr_q  <= rom_q;
      if (state_q == StExecute) result_q <= alu(op, opa, opb);
      if (in_en && (pc_q != '1)) pc_q <= pc_q + 1'b1;
      if (tm1_en) wp1_q <= wp1_q + 1'b1;
      if (tm2_en) wp2_q <= wp2_q + 1'b1;
    end
  end

  calc_trans_mem #(
    .AddrW(TM_ADDR_W),
    .DataW(DATA_W)
  ) u_mem1 (
    .clk_i   (clock),
    .rst_i   (reset),
    .wen_a_i (tm1_en),
    .addr_a_i(wp1_q),
    .din_a_i (result_q[7:0]),
    .ren_b_i (Trans_Mem1_RENB),
    .addr_b_i(Trans_Mem1_ADDRB),
    .dout_b_o(Trans_Mem1_DOUTB)
  );

  calc_trans_mem #(
    .AddrW(TM_ADDR_W),
    .DataW(DATA_W)
  ) u_mem2 (
    .clk_i   (clock),
    .rst_i   (reset),
    .wen_a_i (tm2_en),
    .addr_a_i(wp2_q),
    .din_a_i (result_q[15:8]),
    .ren_b_i (Trans_Mem2_RENB),
    .addr_b_i(Trans_Mem2_ADDRB),
    .dout_b_o(Trans_Mem2_DOUTB)
  );

  assign controller_state    = state_q;
  assign current_instruction = instr_q;
  assign IN_MEM_CNT_EN       = in_en;
  assign TM_MEM1_CNT_EN      = tm1_en;
  assign TM_MEM2_CNT_EN      = tm2_en;

endmodule

// File: tb/tb_top.sv
// Directed bench for the calculator top: reset state, program run, port-B readout, mid-run reset.
module tb_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  addr1, addr2;
  logic        ren1, ren2;
  logic [7:0]  dout1, dout2;
  logic [2:0]  cstate;
  logic [21:0] cinstr;
  logic        in_en, tm1_en, tm2_en;

  integer checks   = 0;
  integer failures = 0;

  logic [7:0] exp1 [16];
  logic [7:0] exp2 [16];

  always #5 clock = ~clock;

  top dut (
    .clock              (clock),
    .reset              (reset),
    .Trans_Mem1_ADDRB   (addr1),
    .Trans_Mem1_RENB    (ren1),
    .Trans_Mem2_ADDRB   (addr2),
    .Trans_Mem2_RENB    (ren2),
    .Trans_Mem1_DOUTB   (dout1),
    .Trans_Mem2_DOUTB   (dout2),
    .controller_state   (cstate),
    .current_instruction(cinstr),
    .IN_MEM_CNT_EN      (in_en),
    .TM_MEM1_CNT_EN     (tm1_en),
    .TM_MEM2_CNT_EN     (tm2_en)
  );

  // Release at a negedge, run n cycles sampling #1 after each edge, and check the outcome.
  task automatic run_program(input string tag, input int n);
    int c_in = 0, c_1 = 0, c_2 = 0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (in_en === 1'b1) c_in++;
      if (tm1_en === 1'b1) c_1++;
      if (tm2_en === 1'b1) c_2++;
    end
    checks++;
    if (cstate !== 3'd5) begin
      failures++;
      $display("FAIL %s_halt: state=%0d required=5", tag, cstate);
    end
    checks++;
    if (c_in != 4) begin
      failures++;
      $display("FAIL %s_in_cnt: pulses=%0d required=4", tag, c_in);
    end
    checks++;
    if (c_1 != 4) begin
      failures++;
      $display("FAIL %s_tm1_cnt: pulses=%0d required=4", tag, c_1);
    end
    checks++;
    if (c_2 != 4) begin
      failures++;
      $display("FAIL %s_tm2_cnt: pulses=%0d required=4", tag, c_2);
    end
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic ren,
                            input logic [7:0] e1, input logic [7:0] e2);
    @(negedge clock);
    addr1 = a;
    addr2 = a;
    ren1  = ren;
    ren2  = ren;
    @(posedge clock);
    #1;
    checks++;
    if (dout1 !== e1 || dout2 !== e2) begin
      failures++;
      $display("FAIL %s addr=%0d: dout1=%h dout2=%h required=%h/%h", tag, a, dout1, dout2,
               e1, e2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (50) @(posedge clock);
    #1;
    checks++;
    if (cstate !== 3'd0 || cinstr !== 22'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d instr=%h required=0/000000", cstate, cinstr);
    end
    checks++;
    if (dout1 !== 8'h00 || dout2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout: dout1=%h dout2=%h required=00/00", dout1, dout2);
    end
    checks++;
    if ({in_en, tm1_en, tm2_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_cnt_en: en=%b required=000", {in_en, tm1_en, tm2_en});
    end
  endtask

  task automatic test_run();
    run_program("run", 20);
  endtask

  task automatic test_readout();
    for (int a = 0; a < 4; a++) read_check("readout", 4'(a), 1'b1, exp1[a], exp2[a]);
  endtask

  task automatic test_ren_hold();
    // Last read left addr 3 on the port; moving the address with RENB low must not update.
    read_check("ren_hold", 4'd0, 1'b0, 8'h1B, 8'h01);
    read_check("ren_hold", 4'd1, 1'b0, 8'h1B, 8'h01);
  endtask

  task automatic test_unused();
    for (int a = 4; a < 16; a++) read_check("unused", 4'(a), 1'b1, 8'h00, 8'h00);
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (cstate !== 3'd0 || cinstr !== 22'd0 || dout1 !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_abort: state=%0d instr=%h dout1=%h required=0/000000/00",
               cstate, cinstr, dout1);
    end
    run_program("rerun", 20);
    for (int a = 0; a < 16; a++) read_check("rerun_mem", 4'(a), 1'b1, exp1[a], exp2[a]);
  endtask

  initial begin
    reset = 1'b1;
    addr1 = '0;
    addr2 = '0;
    ren1  = 1'b0;
    ren2  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp1[i] = 8'h00;
      exp2[i] = 8'h00;
    end
    exp1[0] = 8'h12; exp2[0] = 8'hBA;
    exp1[1] = 8'h1D; exp2[1] = 8'h1D;
    exp1[2] = 8'h1D; exp2[2] = 8'h00;
    exp1[3] = 8'h1B; exp2[3] = 8'h01;

    test_reset();
    test_run();
    test_readout();
    test_ren_hold();
    test_unused();
    test_mid_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
